// File: rtl/disp_scan_ctrl_pkg.sv
// disp_pkg: shared types and constants for the multiplexed 7-segment scan
// controller.
//   state_t        scan FSM encoding (OFF, BLANK, ON)
//   DEF_NUM_DIGITS default number of scanned digits
//   SEG_*          segment glyphs, bit order {a,b,c,d,e,f,g,dp}, 1 = lit
package disp_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    ON    = 2'd2
  } state_t;

  localparam int DEF_NUM_DIGITS = 10;

  localparam logic [7:0] SEG_P     = 8'hCE;
  localparam logic [7:0] SEG_O     = 8'hFC;
  localparam logic [7:0] SEG_S     = 8'hB6;
  localparam logic [7:0] SEG_C     = 8'h9C;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/disp_scan_ctrl_if.sv
// disp_scan_ctrl_if: host/display bundle of the scan controller.
//   host -> ctrl : en, wr_en, wr_addr, wr_data, commit, brightness
//   ctrl -> pins : sel (one-hot digit), segm, cur_digit,
//                  commit_pending, frame_done
// master = host side, slave = controller side.
interface disp_scan_ctrl_if
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS = DEF_NUM_DIGITS,
  parameter int BRIGHT_W   = 4
);
  logic                  en;
  logic                  wr_en;
  logic [3:0]            wr_addr;
  logic [7:0]            wr_data;
  logic                  commit;
  logic [BRIGHT_W-1:0]   brightness;
  logic [NUM_DIGITS-1:0] sel;
  logic [7:0]            segm;
  logic [3:0]            cur_digit;
  logic                  commit_pending;
  logic                  frame_done;

  modport master (
    output en, wr_en, wr_addr, wr_data, commit, brightness,
    input  sel, segm, cur_digit, commit_pending, frame_done
  );

  modport slave (
    input  en, wr_en, wr_addr, wr_data, commit, brightness,
    output sel, segm, cur_digit, commit_pending, frame_done
  );
endinterface

// File: rtl/disp_scan_ctrl_scan_timer.sv
// scan_timer: slot dwell counter (0..DWELL_CYCLES-1) and digit counter
// (0..NUM_DIGITS-1). Both counters clear whenever i_run is low.
//   clk, rst      clock, async active-high reset
//   i_run         advance counters this cycle, else clear to 0
//   o_cur_digit   digit slot currently being scanned
//   o_in_blank    current dwell is inside the leading dark gap
//   o_slot_end    last cycle of the current slot
//   o_frame_end   last cycle of the last slot of the frame
//   o_next_blank  dwell value of the next cycle is inside the dark gap
module scan_timer
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_run,
  output logic [3:0] o_cur_digit,
  output logic       o_in_blank,
  output logic       o_slot_end,
  output logic       o_frame_end,
  output logic       o_next_blank
);

  localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [3:0]    DIGIT_LAST = 4'(NUM_DIGITS - 1);

  logic [DW-1:0] r_dwell;
  logic [DW-1:0] w_dwell_nxt;
  logic [3:0]    r_digit;
  logic [3:0]    w_digit_nxt;

  always_comb begin
    o_slot_end  = (r_dwell == DWELL_LAST);
    o_frame_end = o_slot_end && (r_digit == DIGIT_LAST);
    o_in_blank  = 32'(r_dwell) < 32'(BLANK_CYCLES);
    w_dwell_nxt = '0;
    w_digit_nxt = '0;
    if (i_run) begin
      if (o_slot_end) begin
        w_dwell_nxt = '0;
        w_digit_nxt = o_frame_end ? 4'd0 : r_digit + 4'd1;
      end else begin
        w_dwell_nxt = r_dwell + 1'b1;
        w_digit_nxt = r_digit;
      end
    end
    // Lets the FSM pick BLANK/ON for the coming cycle without duplicating
    // the dwell arithmetic.
    o_next_blank = 32'(w_dwell_nxt) < 32'(BLANK_CYCLES);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell <= '0;
      r_digit <= '0;
    end else begin
      r_dwell <= w_dwell_nxt;
      r_digit <= w_digit_nxt;
    end
  end

  assign o_cur_digit = r_digit;

endmodule

// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: scan controller for a multiplexed 7-segment display.
// Holds a double-buffered frame of segment patterns (host writes the back
// buffer, commit swaps it to the front at the next frame boundary) and
// time-multiplexes the front buffer onto one-hot digit select / segment
// lines with a dark gap at the start of each slot and PWM brightness.
//   clk, rst   clock, async active-high reset
//   bus        disp_scan_ctrl_if.slave (host controls + display outputs)
//
//   state | meaning
//   ------+---------------------------------------------------------
//   OFF   | scanning stopped, display dark, counters held at 0
//   BLANK | leading anti-ghosting gap of a slot, display dark
//   ON    | digit driven, gated by the PWM brightness compare
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16,
  parameter int BRIGHT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  disp_scan_ctrl_if.slave  bus
);

  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_front [NUM_DIGITS];
  logic [7:0]            r_back  [NUM_DIGITS];
  logic [BRIGHT_W-1:0]   r_pwm;
  logic                  r_pending;
  logic                  r_frame_done;
  logic [NUM_DIGITS-1:0] r_sel;
  logic [7:0]            r_segm;

  logic [3:0]            w_cur_digit;
  logic                  w_in_blank;
  logic                  w_slot_end;
  logic                  w_frame_end;
  logic                  w_next_blank;
  logic                  w_run;
  logic                  w_lit;
  logic                  w_show;
  logic                  w_swap;
  logic                  w_wr_ok;
  logic [NUM_DIGITS-1:0] w_onehot;

  assign w_run = bus.en && (r_state != OFF);

  scan_timer #(
    .NUM_DIGITS  (NUM_DIGITS),
    .DWELL_CYCLES(DWELL_CYCLES),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_scan_timer (
    .clk         (clk),
    .rst         (rst),
    .i_run       (w_run),
    .o_cur_digit (w_cur_digit),
    .o_in_blank  (w_in_blank),
    .o_slot_end  (w_slot_end),
    .o_frame_end (w_frame_end),
    .o_next_blank(w_next_blank)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= OFF;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.en) begin
      w_state_nxt = OFF;
    end else begin
      case (r_state)
        OFF:     w_state_nxt = HAS_BLANK ? BLANK : ON;
        BLANK:   w_state_nxt = w_next_blank ? BLANK : ON;
        ON:      w_state_nxt = (w_slot_end && HAS_BLANK) ? BLANK : ON;
        default: w_state_nxt = OFF;
      endcase
    end
  end

  always_comb begin
    w_lit    = (&bus.brightness) || (r_pwm < bus.brightness);
    // en gates the drive directly so dropping it darkens the pins on the
    // very next edge rather than one cycle later.
    w_show   = bus.en && (r_state == ON) && !w_in_blank && w_lit;
    w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << w_cur_digit;
    // OFF has no frame boundary to wait for, so a pending swap is immediate.
    w_swap   = r_pending && ((r_state == OFF) || w_frame_end);
    w_wr_ok  = bus.wr_en && (int'(bus.wr_addr) < NUM_DIGITS);
  end

  // Front is only ever loaded from back, so a write in the swap cycle lands
  // in back after the copy and waits for the next commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        r_front[i] <= '0;
        r_back[i]  <= '0;
      end
    end else begin
      if (w_swap) r_front <= r_back;
      if (w_wr_ok) r_back[bus.wr_addr] <= bus.wr_data;
    end
  end

  // A commit arriving together with a swap is a new request for the next
  // frame, hence commit has priority over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending    <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      if (bus.commit)  r_pending <= 1'b1;
      else if (w_swap) r_pending <= 1'b0;
      r_frame_done <= w_swap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                r_pwm <= '0;
    else if (r_state == ON) r_pwm <= r_pwm + 1'b1;
    else                    r_pwm <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel  <= '0;
      r_segm <= '0;
    end else begin
      r_sel  <= w_show ? w_onehot : '0;
      r_segm <= w_show ? r_front[w_cur_digit] : SEG_BLANK;
    end
  end

  assign bus.sel            = r_sel;
  assign bus.segm           = r_segm;
  assign bus.cur_digit      = w_cur_digit;
  assign bus.commit_pending = r_pending;
  assign bus.frame_done     = r_frame_done;

endmodule
